// File: rtl/moore_1011.sv
// Moore detector for the serial pattern 1011 (first bit first).
// z is decoded from the state register alone, so it has no combinational path from x.
module moore_1011 #(
  parameter int OVERLAP = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic x,
  output logic z
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  // Kept as a plain 3-bit vector so that the unused codes 5..7 stay representable.
  logic [2:0] r_state;
  state_t     w_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S0;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = S0;
    case (r_state)
      S0: w_next = x ? S1 : S0;
      S1: w_next = x ? S1 : S2;
      S2: w_next = x ? S3 : S0;
      S3: w_next = x ? S4 : S2;
      // After a match, the trailing 1 may begin the next match ("10" suffix) only when overlapping.
      S4: begin
        if (x) begin
          w_next = S1;
        end else begin
          w_next = (OVERLAP != 0) ? S2 : S0;
        end
      end
      default: w_next = S0;
    endcase
  end

  assign z = (r_state == S4);

endmodule

// File: tb/tb_moore_1011.sv
// Bench for moore_1011: overlapping and non-overlapping instances share one stimulus stream
// and are compared every cycle against a bit-history model of the pattern rules.
module tb_moore_1011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic x   = 1'b0;
  logic z_ov;
  logic z_no;

  always #5 clk = ~clk;

  moore_1011 #(.OVERLAP(1)) u_ov (.clk(clk), .rst(rst), .x(x), .z(z_ov));
  moore_1011 #(.OVERLAP(0)) u_no (.clk(clk), .rst(rst), .x(x), .z(z_no));

  int n_checks = 0;
  int n_fail   = 0;

  // Model: bits seen since reset (overlap) or since reset / last match (non-overlap).
  bit hist_ov[$];
  bit hist_no[$];
  bit exp_ov;
  bit exp_no;
  int pos_ov[$];
  int pos_no[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit ends_1011(input bit q[$]);
    if (q.size() < 4) return 1'b0;
    return (q[q.size()-4] == 1'b1) && (q[q.size()-3] == 1'b0) &&
           (q[q.size()-2] == 1'b1) && (q[q.size()-1] == 1'b1);
  endfunction

  task automatic model_clear();
    hist_ov.delete();
    hist_no.delete();
    exp_ov = 1'b0;
    exp_no = 1'b0;
  endtask

  task automatic model_step(input bit b, input bit r);
    if (r) begin
      model_clear();
    end else begin
      hist_ov.push_back(b);
      if (hist_ov.size() > 4) void'(hist_ov.pop_front());
      exp_ov = ends_1011(hist_ov);
      hist_no.push_back(b);
      exp_no = ends_1011(hist_no);
      if (exp_no) hist_no.delete();
    end
  endtask

  task automatic step(input bit b, input bit r, input string tag);
    @(negedge clk);
    x   = b;
    rst = r;
    @(posedge clk);
    #1;
    model_step(b, r);
    chk({tag, "_z_ov"}, {31'd0, z_ov}, {31'd0, exp_ov});
    chk({tag, "_z_no"}, {31'd0, z_no}, {31'd0, exp_no});
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1, "reset");
    pos_ov.delete();
    pos_no.delete();
  endtask

  task automatic run_str(input string s, input string tag);
    for (int i = 0; i < s.len(); i++) begin
      step(s[i] == "1", 1'b0, tag);
      if (z_ov === 1'b1) pos_ov.push_back(i + 1);
      if (z_no === 1'b1) pos_no.push_back(i + 1);
    end
  endtask

  initial begin
    string near[4];
    logic [2:0] bad;

    // Reset held for two edges with x=1.
    step(1'b1, 1'b1, "rst_hold");
    step(1'b1, 1'b1, "rst_hold");
    chk("rst_state", {29'd0, u_ov.r_state}, 32'd0);
    chk("rst_z", {31'd0, z_ov}, 32'd0);
    pos_ov.delete();
    pos_no.delete();
    run_str("1011", "basic");
    chk("basic_cnt", pos_ov.size(), 32'd1);
    if (pos_ov.size() == 1) chk("basic_pos", pos_ov[0], 32'd4);

    // Overlapping vs non-overlapping stream.
    do_reset();
    run_str("0001011011100000", "stream");
    chk("stream_ov_cnt", pos_ov.size(), 32'd2);
    if (pos_ov.size() == 2) begin
      chk("stream_ov_p0", pos_ov[0], 32'd7);
      chk("stream_ov_p1", pos_ov[1], 32'd10);
    end
    chk("stream_no_cnt", pos_no.size(), 32'd1);
    if (pos_no.size() == 1) chk("stream_no_p0", pos_no[0], 32'd7);

    // Near-misses, reset between each.
    near[0] = "1001";
    near[1] = "1010";
    near[2] = "0110";
    near[3] = "11011";
    for (int k = 0; k < 4; k++) begin
      do_reset();
      run_str(near[k], "near");
      chk("near_cnt", pos_ov.size(), (k == 3) ? 32'd1 : 32'd0);
    end
    if (pos_ov.size() == 1) chk("near_11011_pos", pos_ov[0], 32'd5);

    // Reset mid-pattern discards progress.
    do_reset();
    run_str("101", "mid");
    step(1'b1, 1'b1, "mid_rst");
    pos_ov.delete();
    pos_no.delete();
    run_str("1", "mid_after");
    chk("mid_nopulse", pos_ov.size(), 32'd0);
    run_str("011", "mid_after");
    chk("mid_cnt", pos_ov.size(), 32'd1);
    chk("mid_cnt_no", pos_no.size(), 32'd1);

    // Illegal-state recovery for each code and each x value.
    for (int v = 5; v < 8; v++) begin
      for (int b = 0; b < 2; b++) begin
        bad = v[2:0];
        @(negedge clk);
        x   = b[0];
        rst = 1'b0;
        force u_ov.r_state = bad;
        force u_no.r_state = bad;
        #1;
        chk("illegal_z_ov", {31'd0, z_ov}, 32'd0);
        chk("illegal_z_no", {31'd0, z_no}, 32'd0);
        release u_ov.r_state;
        release u_no.r_state;
        @(posedge clk);
        #1;
        model_clear();
        chk("illegal_next_ov", {29'd0, u_ov.r_state}, 32'd0);
        chk("illegal_next_no", {29'd0, u_no.r_state}, 32'd0);
      end
    end

    // Randomized stream with occasional resets; model checked every cycle.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/moore_1011.md
Name: moore_1011

Overview:
- Moore-type serial sequence detector that watches a 1-bit input stream for the pattern 1011, with the first bit received first.
- Output z depends only on the current state. It asserts for one full clock cycle after the fourth bit of the pattern is sampled.
- Used as a standalone pattern-recognition block on a single-bit serial data line in the same clock domain.

Parameters:
- OVERLAP, default 1. 1 = overlapping detection: the trailing "1" of a match can start the next match. 0 = non-overlapping: detection restarts from scratch after a match.

Ports:
- clk  input  1  System clock; all state updates on rising edge.
- rst  input  1  Synchronous, active-high reset.
- x  input  1  Serial data bit, sampled on each rising edge of clk.
- z  output  1  Detect flag; 1 while the FSM is in the match state.

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high.
- x is sampled only at the rising edge of clk. Drivers must change x away from the rising edge, e.g. on the falling edge or after a delay.
- State register is 3 bits, binary encoded:
  - S0=0: idle / nothing matched.
  - S1=1: seen "1".
  - S2=2: seen "10".
  - S3=3: seen "101".
  - S4=4: seen "1011", the match state.
- Reset:
  - rst=1 at a rising edge loads S0, regardless of x. rst has priority over all transitions.
  - z=0 from the cycle after that edge.
  - Reset asserted mid-pattern discards all partial progress.
- Transitions (x=0 / x=1):
  - S0 -> S0 / S1
  - S1 -> S2 / S1
  - S2 -> S0 / S3
  - S3 -> S2 / S4
  - S4 with OVERLAP=1 -> S2 / S1
  - S4 with OVERLAP=0 -> S0 / S1. A trailing "1" after a match is treated as a fresh start, not a continuation.
- Output:
  - z = 1 if and only if state == S4, decoded combinationally from the state register only. There is no direct combinational path from x to z.
  - Latency: z rises in the clock cycle following the rising edge that samples the final "1" of 1011. It stays high for exactly one cycle unless the following bits complete another match.
- Illegal states 5, 6, 7: z=0, and the next rising edge goes to S0 regardless of x.
- Consecutive matches: in overlap mode, stream 1011011 yields two z pulses, 3 cycles apart.
- No other outputs, no enable, no handshake. x is processed every cycle.

Test Plan:
- Reset: hold rst=1 for 2 edges with x=1 -> state S0, z=0. Release rst; x=1,0,1,1 -> z=1 for exactly the cycle after the 4th edge.
- Overlap stream (OVERLAP=1): x = 0001011011100000, MSB first, one bit per edge after reset -> z pulses exactly twice, in the cycles after bits 7 and 10 (1-indexed). z=0 at all other times.
- Same stream with OVERLAP=0 -> exactly one z pulse, after bit 7.
- Near-misses: x = 1001, 1010, 0110, 11011 with reset between patterns -> z=0 for the first three. 11011 -> one pulse after the 5th bit, since the S1 self-loop on repeated 1s is exercised.
- Reset mid-pattern: x=1,0,1, then rst=1 for one edge, then x=1 -> no z pulse. Then x=0,1,1 -> pulse after the last bit (pattern 1011 starting from the post-reset 1).
- Illegal state recovery: force state register to 5, 6 and 7 in turn -> z=0 in each. Next edge gives state S0 for both x=0 and x=1.
